nexys_starship_monster_scheduler: RTL and testbench



---
 rtl/nexys_starship_monster_scheduler.sv | 154 +++++++++++++++
 tb/tb_nexys_starship_monster_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nexys_starship_monster_scheduler.sv
`default_nettype none
// ==========================================================================
// nexys_starship_monster_scheduler - paced, LFSR-steered monster spawn requests
// Rev 1.0
// ==========================================================================
module nexys_starship_monster_scheduler #(
  parameter int          SPAWN_PERIOD = 100000000,
  parameter int          MIN_PERIOD   = 25000000,
  parameter int          PERIOD_STEP  = 10000000,
  parameter int          TIMER_W      = 27,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       game_over,
  input  logic [3:0] busy,
  output logic [3:0] spawn,
  output logic [7:0] rand_out,
  output logic [7:0] spawn_count,
  output logic       q_Idle,
  output logic       q_Wait,
  output logic       q_Pick,
  output logic       q_Issue
);

  localparam logic [15:0]        c_SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]        c_MASK  = 16'hB400;
  localparam logic [TIMER_W-1:0] c_SPAWN = TIMER_W'(SPAWN_PERIOD);
  localparam logic [TIMER_W-1:0] c_MIN   = TIMER_W'(MIN_PERIOD);
  localparam logic [TIMER_W-1:0] c_STEP  = TIMER_W'(PERIOD_STEP);
  localparam logic [TIMER_W-1:0] c_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W:0]   c_FLOOR = (TIMER_W+1)'(MIN_PERIOD) + (TIMER_W+1)'(PERIOD_STEP);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_PICK  = 4'b0100,
    S_ISSUE = 4'b1000
  } state_t;

  state_t             state_q;
  logic [15:0]        lfsr_q;
  logic [15:0]        lfsr_d;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] period_q;
  logic [TIMER_W-1:0] period_d;
  logic [7:0]         count_q;
  logic [7:0]         count_d;
  logic [3:0]         spawn_q;
  logic [3:0]         pick_d;
  logic               pick_found;
  logic [1:0]         side_idx;
  logic               abort;

  assign abort = game_over | ~play_flag;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_MASK : 16'h0000);

    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    // Period shrinks on every 8th spawn; the floor comparison is done one bit
    // wider so MIN_PERIOD + PERIOD_STEP cannot wrap.
    period_d = period_q;
    if (count_d[2:0] == 3'b000) begin
      if ({1'b0, period_q} >= c_FLOOR) begin
        period_d = period_q - c_STEP;
      end else begin
        period_d = c_MIN;
      end
    end
  end

  // First free side in round-robin order starting from the LFSR candidate.
  always_comb begin
    pick_found = 1'b0;
    pick_d     = 4'b0000;
    side_idx   = 2'b00;
    for (int i = 0; i < 4; i++) begin
      side_idx = lfsr_q[1:0] + 2'(i);
      if (!pick_found && !busy[side_idx]) begin
        pick_found = 1'b1;
        pick_d     = 4'b0001 << side_idx;
      end
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= c_SEED;
      timer_q  <= '0;
      period_q <= c_SPAWN;
      count_q  <= 8'd0;
      spawn_q  <= 4'b0000;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        S_IDLE: begin
          spawn_q <= 4'b0000;
          if (!abort) begin
            state_q  <= S_WAIT;
            timer_q  <= c_SPAWN - c_ONE;
            period_q <= c_SPAWN;
            count_q  <= 8'd0;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (timer_q == '0) begin
            state_q <= S_PICK;
          end else begin
            timer_q <= timer_q - c_ONE;
          end
        end
        S_PICK: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (pick_found) begin
            spawn_q <= pick_d;
            state_q <= S_ISSUE;
          end else begin
            timer_q <= period_q - c_ONE;
            state_q <= S_WAIT;
          end
        end
        S_ISSUE: begin
          // The registered spawn always completes; abort only redirects the exit.
          spawn_q  <= 4'b0000;
          count_q  <= count_d;
          period_q <= period_d;
          timer_q  <= period_d - c_ONE;
          state_q  <= abort ? S_IDLE : S_WAIT;
        end
        default: begin
          spawn_q <= 4'b0000;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign spawn       = spawn_q;
  assign rand_out    = lfsr_q[7:0];
  assign spawn_count = count_q;
  assign q_Idle      = (state_q == S_IDLE);
  assign q_Wait      = (state_q == S_WAIT);
  assign q_Pick      = (state_q == S_PICK);
  assign q_Issue     = (state_q == S_ISSUE);

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_monster_scheduler.sv
`default_nettype none
// Testbench for nexys_starship_monster_scheduler: random side choices predicted by a software LFSR.
module tb_nexys_starship_monster_scheduler;

  localparam int SP   = 16;
  localparam int MINP = 4;
  localparam int STEP = 4;

  logic       board_clk;
  logic       Reset;
  logic       play_flag;
  logic       game_over;
  logic [3:0] busy;
  logic [3:0] spawn;
  logic [7:0] rand_out;
  logic [7:0] spawn_count;
  logic       q_Idle, q_Wait, q_Pick, q_Issue;

  int checks = 0;
  int errors = 0;

  nexys_starship_monster_scheduler #(
    .SPAWN_PERIOD(SP), .MIN_PERIOD(MINP), .PERIOD_STEP(STEP), .TIMER_W(27), .LFSR_SEED(16'hACE1)
  ) dut (
    .board_clk(board_clk), .Reset(Reset), .play_flag(play_flag), .game_over(game_over),
    .busy(busy), .spawn(spawn), .rand_out(rand_out), .spawn_count(spawn_count),
    .q_Idle(q_Idle), .q_Wait(q_Wait), .q_Pick(q_Pick), .q_Issue(q_Issue)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  // Software LFSR tracking the value the DUT should hold in every cycle.
  logic [15:0] m_lfsr;
  always @(posedge board_clk or posedge Reset) begin
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  function automatic logic [3:0] exp_side(input logic [15:0] l, input logic [3:0] b);
    for (int k = 0; k < 4; k++) begin
      int sd;
      sd = (int'(l[1:0]) + k) % 4;
      if (!b[sd]) return 4'b0001 << sd;
    end
    return 4'b0000;
  endfunction

  function automatic int next_period(input int p, input int n);
    if (n % 8 == 0) return (p - STEP > MINP) ? p - STEP : MINP;
    return p;
  endfunction

  task automatic do_reset();
    play_flag = 1'b0; game_over = 1'b0; busy = 4'b0000; Reset = 1'b1;
    repeat (2) @(negedge board_clk);
    Reset = 1'b0;
  endtask

  // Waits for the next non-zero spawn; reports cycles elapsed and the LFSR seen during PICK.
  task automatic wait_spawn(input int limit, output int cycles, output logic [3:0] s,
                            output logic [15:0] pick_lfsr, output int bad_lfsr,
                            output int bad_rand, output bit timeout);
    logic [15:0] prev;
    cycles = 0; timeout = 1'b0; bad_lfsr = 0; bad_rand = 0; s = 4'b0000;
    prev = m_lfsr; pick_lfsr = m_lfsr;
    while (1) begin
      @(negedge board_clk);
      cycles++;
      if (m_lfsr == 16'h0000) bad_lfsr++;
      if (rand_out !== m_lfsr[7:0]) bad_rand++;
      if (spawn !== 4'b0000) begin
        s = spawn; pick_lfsr = prev;
        break;
      end
      if (cycles >= limit) begin
        timeout = 1'b1;
        break;
      end
      prev = m_lfsr;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; play_flag = 1'b1; game_over = 1'b0; busy = 4'b0000;
    @(negedge board_clk);
    Reset = 1'b1;
    @(negedge board_clk);
    checks++;
    if ({q_Issue, q_Pick, q_Wait, q_Idle} !== 4'b0001) begin
      errors++; $display("FAIL reset_state: got %b expected 0001", {q_Issue, q_Pick, q_Wait, q_Idle});
    end
    checks++;
    if (spawn !== 4'b0000 || spawn_count !== 8'd0) begin
      errors++; $display("FAIL reset_outputs: spawn %b count %0d expected 0 and 0", spawn, spawn_count);
    end
    checks++;
    if (rand_out !== 8'hE1) begin
      errors++; $display("FAIL reset_rand: got %h expected e1", rand_out);
    end
    play_flag = 1'b0; Reset = 1'b0;
    repeat (3) @(negedge board_clk);
    checks++;
    if (q_Idle !== 1'b1 || rand_out !== m_lfsr[7:0]) begin
      errors++; $display("FAIL idle_lfsr: idle %b rand %h expected 1 %h", q_Idle, rand_out, m_lfsr[7:0]);
    end
  endtask

  task automatic test_first_spawn();
    logic [15:0] pl;
    int          stray;
    do_reset();
    play_flag = 1'b1;
    @(negedge board_clk);
    checks++;
    if (q_Wait !== 1'b1 || q_Idle !== 1'b0) begin
      errors++; $display("FAIL first_wait: wait %b idle %b expected 1 0", q_Wait, q_Idle);
    end
    stray = 0; pl = 16'h0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge board_clk);
      if (spawn !== 4'b0000) stray++;
      if (i == 16) pl = m_lfsr;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL first_early_spawn: got %0d stray cycles expected 0", stray);
    end
    checks++;
    if (q_Pick !== 1'b1) begin
      errors++; $display("FAIL first_pick: got %b expected 1", q_Pick);
    end
    @(negedge board_clk);
    checks++;
    if (spawn !== (4'b0001 << pl[1:0])) begin
      errors++; $display("FAIL first_side: got %b expected %b", spawn, 4'b0001 << pl[1:0]);
    end
    @(negedge board_clk);
    checks++;
    if (spawn !== 4'b0000 || spawn_count !== 8'd1 || q_Wait !== 1'b1) begin
      errors++; $display("FAIL first_after: spawn %b count %0d wait %b expected 0000 1 1", spawn, spawn_count, q_Wait);
    end
  endtask

  task automatic test_steering();
    int p, n, cyc, bl, br;
    logic [3:0] s;
    logic [15:0] pl;
    bit to;
    do_reset();
    busy = 4'b1101; play_flag = 1'b1;
    p = SP; n = 0;
    for (int k = 1; k <= 20; k++) begin
      wait_spawn(p + 10, cyc, s, pl, bl, br, to);
      checks++;
      if (to || cyc != p + 2) begin
        errors++; $display("FAIL steer_spacing: spawn %0d got %0d cycles expected %0d", k, cyc, p + 2);
      end
      checks++;
      if (s !== 4'b0010 || s !== exp_side(pl, busy)) begin
        errors++; $display("FAIL steer_side: spawn %0d got %b expected 0010", k, s);
      end
      checks++;
      if (spawn_count !== 8'(n) || br != 0) begin
        errors++; $display("FAIL steer_count: spawn %0d count %0d rand_err %0d expected %0d 0", k, spawn_count, br, n);
      end
      n = (n < 255) ? n + 1 : 255;
      p = next_period(p, n);
    end
  endtask

  task automatic test_all_busy();
    do_reset();
    busy = 4'b1111; play_flag = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge board_clk);
      checks++;
      if (spawn !== 4'b0000) begin
        errors++; $display("FAIL busy_spawn: cycle %0d got %b expected 0000", i, spawn);
      end
      checks++;
      if (q_Pick !== (i % 17 == 0)) begin
        errors++; $display("FAIL busy_pick: cycle %0d got %b expected %b", i, q_Pick, (i % 17 == 0));
      end
    end
    checks++;
    if (spawn_count !== 8'd0) begin
      errors++; $display("FAIL busy_count: got %0d expected 0", spawn_count);
    end
  endtask

  task automatic test_abort();
    int cyc, bl, br, guard;
    logic [3:0] s;
    logic [15:0] pl;
    bit to;
    do_reset();
    busy = 4'b0000; play_flag = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      wait_spawn(40, cyc, s, pl, bl, br, to);
      checks++;
      if (to) begin
        errors++; $display("FAIL abort_setup: spawn %0d got timeout expected spawn", k);
      end
    end
    // game_over while in WAIT
    guard = 0;
    while (q_Wait !== 1'b1 && guard < 40) begin @(negedge board_clk); guard++; end
    game_over = 1'b1;
    @(negedge board_clk);
    checks++;
    if (q_Idle !== 1'b1 || spawn !== 4'b0000) begin
      errors++; $display("FAIL abort_wait: idle %b spawn %b expected 1 0000", q_Idle, spawn);
    end
    game_over = 1'b0; play_flag = 1'b0;
    repeat (2) @(negedge board_clk);
    checks++;
    if (q_Idle !== 1'b1 || spawn_count !== 8'd9) begin
      errors++; $display("FAIL abort_hold: idle %b count %0d expected 1 9", q_Idle, spawn_count);
    end
    // replay, then game_over while in PICK
    play_flag = 1'b1;
    guard = 0;
    do begin @(negedge board_clk); guard++; end while (q_Pick !== 1'b1 && guard < 40);
    checks++;
    if (guard != 17) begin
      errors++; $display("FAIL abort_pick_time: got %0d cycles expected 17", guard);
    end
    game_over = 1'b1;
    @(negedge board_clk);
    checks++;
    if (q_Idle !== 1'b1 || spawn !== 4'b0000 || spawn_count !== 8'd0) begin
      errors++; $display("FAIL abort_pick: idle %b spawn %b count %0d expected 1 0000 0", q_Idle, spawn, spawn_count);
    end
    game_over = 1'b0;
    wait_spawn(40, cyc, s, pl, bl, br, to);
    checks++;
    if (to || cyc != SP + 2 || s !== exp_side(pl, busy)) begin
      errors++; $display("FAIL abort_restart: got %0d cycles side %b expected %0d %b", cyc, s, SP + 2, exp_side(pl, busy));
    end
    // drop play_flag during ISSUE: spawn completes, then IDLE
    play_flag = 1'b0;
    @(negedge board_clk);
    checks++;
    if (q_Idle !== 1'b1 || spawn !== 4'b0000 || spawn_count !== 8'd1) begin
      errors++; $display("FAIL abort_issue: idle %b spawn %b count %0d expected 1 0000 1", q_Idle, spawn, spawn_count);
    end
  endtask

  task automatic test_saturation();
    int p, n, cyc, bl, br, tot_bad, sp_err, side_err, cnt_err;
    logic [3:0] s;
    logic [15:0] pl;
    bit to;
    do_reset();
    play_flag = 1'b1;
    p = SP; n = 0; tot_bad = 0; sp_err = 0; side_err = 0; cnt_err = 0;
    for (int k = 1; k <= 300; k++) begin
      busy = 4'($urandom_range(0, 14));
      wait_spawn(p + 10, cyc, s, pl, bl, br, to);
      tot_bad += bl + br;
      checks++;
      if (to || cyc != p + 2) begin
        errors++; sp_err++;
        if (sp_err < 5) $display("FAIL sat_spacing: spawn %0d got %0d cycles expected %0d", k, cyc, p + 2);
      end
      checks++;
      if (s !== exp_side(pl, busy)) begin
        errors++; side_err++;
        if (side_err < 5) $display("FAIL sat_side: spawn %0d got %b expected %b", k, s, exp_side(pl, busy));
      end
      checks++;
      if (spawn_count !== 8'(n)) begin
        errors++; cnt_err++;
        if (cnt_err < 5) $display("FAIL sat_count: spawn %0d got %0d expected %0d", k, spawn_count, n);
      end
      n = (n < 255) ? n + 1 : 255;
      p = next_period(p, n);
      busy = 4'b0000;
    end
    @(negedge board_clk);
    checks++;
    if (spawn_count !== 8'd255) begin
      errors++; $display("FAIL sat_final: got %0d expected 255", spawn_count);
    end
    checks++;
    if (tot_bad != 0) begin
      errors++; $display("FAIL sat_lfsr: got %0d bad lfsr cycles expected 0", tot_bad);
    end
  endtask

  task automatic test_reset_in_issue();
    int cyc, bl, br;
    logic [3:0] s;
    logic [15:0] pl;
    bit to;
    do_reset();
    play_flag = 1'b1;
    wait_spawn(40, cyc, s, pl, bl, br, to);
    checks++;
    if (to || q_Issue !== 1'b1) begin
      errors++; $display("FAIL rst_issue_setup: issue %b expected 1", q_Issue);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (spawn !== 4'b0000 || q_Idle !== 1'b1 || rand_out !== 8'hE1) begin
      errors++; $display("FAIL rst_issue: spawn %b idle %b rand %h expected 0000 1 e1", spawn, q_Idle, rand_out);
    end
    @(negedge board_clk);
    Reset = 1'b0; play_flag = 1'b0;
  endtask

  initial begin
    Reset = 1'b0; play_flag = 1'b0; game_over = 1'b0; busy = 4'b0000;
    test_reset();
    test_first_spawn();
    test_steering();
    test_all_busy();
    test_abort();
    test_saturation();
    test_reset_in_issue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
